// File: rtl/apb4_master_bridge_if.sv
// Host command/response channels and APB4 bus signals of apb4_master_bridge.
// The bridge connects through the master modport; the host/slave side uses slave.
interface apb4_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_strb;
    logic [2:0]                cmd_prot;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic                      pslverr;
    logic [DATA_WIDTH-1:0]     prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 master: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns status on a valid/ready response channel.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                  clk,
    input logic                  rst,
    apb4_master_bridge_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_WIDTH  = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
    logic [CNT_WIDTH-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0]    wait_cnt_inc;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        wait_cnt_inc  = wait_cnt_q + CNT_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_addr[1:0] == 2'b00) begin
                        state_d    = SETUP;
                        pwrite_d   = bus.cmd_write;
                        paddr_d    = bus.cmd_addr;
                        pwdata_d   = bus.cmd_wdata;
                        pstrb_d    = bus.cmd_write ? bus.cmd_strb : '0;
                        pprot_d    = bus.cmd_prot;
                        wait_cnt_d = '0;
                    end else begin
                        // Misaligned: answer locally, the APB bus never sees it.
                        state_d       = RESP;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready) begin
                    state_d       = RESP;
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
                end else if (TIMEOUT_EN) begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == CNT_LIMIT) begin
                        state_d       = RESP;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: async reset of the state register drops psel/penable the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            wait_cnt_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable     = (state_q == ACCESS);
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed bench for apb4_master_bridge: a cycle-offset transaction model is
// compared against the DUT every cycle, plus literal latency/data expectations.
module tb_apb4_master_bridge;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb4_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction model: expected outputs as a function of cycles since accept.
    logic        m_active = 1'b0;
    int          m_start  = 0;
    int          ncyc     = 0;
    logic        m_mis, m_write, m_err, m_to;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    int          m_nacc;

    // Slave behaviour: pready after sl_wait low ACCESS cycles; junk data otherwise.
    int          sl_wait  = 0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = '0;
    int          acc_j    = 0;

    always @(negedge clk) begin
        if (bus.psel && bus.penable) begin
            acc_j       <= acc_j + 1;
            bus.pready  <= (acc_j == sl_wait);
            bus.pslverr <= (acc_j == sl_wait) ? sl_err : 1'b1;
            bus.prdata  <= (acc_j == sl_wait) ? sl_rdata : 32'hBAD0_BAD0;
        end else begin
            acc_j       <= 0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= 32'hBAD0_BAD0;
        end
    end

    always @(negedge clk) begin : cmp
        int   k;
        logic e_psel, e_pen, e_rv;
        ncyc <= ncyc + 1;
        if (rst) begin
            check("rst_psel", bus.psel, 1'b0);
            check("rst_penable", bus.penable, 1'b0);
            check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        end else if (!m_active) begin
            check("idle_cmd_ready", bus.cmd_ready, 1'b1);
            check("idle_psel", bus.psel, 1'b0);
            check("idle_penable", bus.penable, 1'b0);
            check("idle_rsp_valid", bus.rsp_valid, 1'b0);
        end else begin
            k      = ncyc - m_start;
            e_psel = !m_mis && (k <= m_nacc);
            e_pen  = !m_mis && (k >= 1) && (k <= m_nacc);
            e_rv   = m_mis || (k > m_nacc);
            check("busy_cmd_ready", bus.cmd_ready, 1'b0);
            check("psel", bus.psel, e_psel);
            check("penable", bus.penable, e_pen);
            check("rsp_valid", bus.rsp_valid, e_rv);
            if (e_psel) begin
                check("paddr", bus.paddr, m_addr);
                check("pwrite", bus.pwrite, m_write);
                check("pwdata", bus.pwdata, m_wdata);
                check("pstrb", bus.pstrb, m_write ? m_strb : 4'h0);
                check("pprot", bus.pprot, m_prot);
            end
            if (e_rv) begin
                check("rsp_rdata", bus.rsp_rdata, m_rdata);
                check("rsp_err", bus.rsp_err, m_err);
                check("rsp_timeout", bus.rsp_timeout, m_to);
            end
        end
    end

    task automatic do_txn(
        input  logic wr, input logic [31:0] addr, input logic [31:0] wdata,
        input  logic [3:0] strb, input logic [2:0] prot,
        input  int wait_st, input logic serr, input logic [31:0] rdata,
        input  int rsp_hold, input logic junk, input int abort_k,
        output int lat, output int n_pen, output int st,
        output logic [31:0] r_rdata, output logic r_err, output logic r_to);
        int k;
        int rv_n;
        bit done;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.cmd_prot  = prot;
        bus.cmd_valid = 1'b1;
        sl_wait  = wait_st;
        sl_err   = serr;
        sl_rdata = rdata;
        m_mis   = (addr[1:0] != 2'b00);
        m_to    = !m_mis && (wait_st >= TO);
        m_nacc  = m_to ? TO : wait_st + 1;
        m_err   = m_mis || m_to || serr;
        m_rdata = (wr || m_err) ? 32'h0 : rdata;
        m_write = wr;
        m_addr  = addr;
        m_wdata = wdata;
        m_strb  = strb;
        m_prot  = prot;
        @(posedge clk);
        m_start  = ncyc;
        m_active = 1'b1;
        st = ncyc;
        lat = -1; n_pen = 0; rv_n = 0; done = 0;
        r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            k = ncyc - m_start;
            if (k == 0) begin
                if (junk) begin
                    bus.cmd_addr  = 32'hFFFF_FFF3;
                    bus.cmd_write = ~wr;
                    bus.cmd_wdata = ~wdata;
                    bus.cmd_strb  = ~strb;
                    bus.cmd_prot  = ~prot;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            if (bus.penable) n_pen++;
            if (k == abort_k) begin
                #2 rst = 1'b1;
                #1;
                check("async_psel", bus.psel, 1'b0);
                check("async_penable", bus.penable, 1'b0);
                bus.cmd_valid = 1'b0;
                m_active = 1'b0;
                @(negedge clk);
                #2 rst = 1'b0;
                done = 1;
            end else if (bus.rsp_valid) begin
                if (lat < 0) lat = k;
                r_rdata = bus.rsp_rdata;
                r_err   = bus.rsp_err;
                r_to    = bus.rsp_timeout;
                if (rv_n == rsp_hold) begin
                    bus.rsp_ready = 1'b1;
                    bus.cmd_valid = 1'b0;
                    @(posedge clk);
                    m_active = 1'b0;
                    done = 1;
                end
                rv_n++;
            end
        end
        check("txn_completed", done, 1'b1);
        if (!done) begin
            bus.cmd_valid = 1'b0;
            m_active = 1'b0;
        end
    endtask

    initial begin
        int          lat, npen, st, st_prev;
        logic [31:0] rd;
        logic        er, tmo;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pwrite", bus.pwrite, 1'b0);
        check("rst_paddr", bus.paddr, 32'h0);
        check("rst_pwdata", bus.pwdata, 32'h0);
        check("rst_pstrb", bus.pstrb, 4'h0);
        check("rst_pprot", bus.pprot, 3'h0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        #2 rst = 1'b0;

        // Zero-wait write, then a back-to-back zero-wait read.
        do_txn(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("wr0_latency", lat, 2);
        check("wr0_penable_cycles", npen, 1);
        check("wr0_rdata", rd, 32'h0);
        check("wr0_err", er, 1'b0);
        st_prev = st;
        do_txn(1'b0, 32'h8, 32'h1111_1111, 4'hF, 3'b001, 0, 1'b0, 32'hA5A5_0001, 0, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("b2b_spacing", st - st_prev, 4);
        check("rd0_rdata", rd, 32'hA5A5_0001);

        // Read with 3 wait states while junk commands stay on the input.
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 1, 1'b1, -1,
               lat, npen, st, rd, er, tmo);
        check("rd3_latency", lat, 5);
        check("rd3_penable_cycles", npen, 4);
        check("rd3_rdata", rd, 32'h1234_5678);

        // Slave errors on a read and on a write with one wait state.
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 0, 1'b1, 32'hCAFE_F00D, 0, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("slverr_err", er, 1'b1);
        check("slverr_timeout", tmo, 1'b0);
        check("slverr_rdata", rd, 32'h0);
        do_txn(1'b1, 32'h24, 32'h0F0F_0F0F, 4'h5, 3'b100, 1, 1'b1, 32'hFFFF_FFFF, 2, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("wrerr_err", er, 1'b1);

        // Timeout with pready held low, then pready in the last counted cycle.
        do_txn(1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 100, 1'b0, 32'h77, 0, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("to_penable_cycles", npen, 8);
        check("to_latency", lat, 9);
        check("to_err", er, 1'b1);
        check("to_timeout", tmo, 1'b1);
        check("to_rdata", rd, 32'h0);
        do_txn(1'b0, 32'h34, 32'h0, 4'hF, 3'b011, 7, 1'b0, 32'h8765_4321, 0, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("last_ready_penable_cycles", npen, 8);
        check("last_ready_timeout", tmo, 1'b0);
        check("last_ready_rdata", rd, 32'h8765_4321);
        do_txn(1'b1, 32'h38, 32'h1212_1212, 4'hC, 3'b000, 50, 1'b0, 32'h0, 0, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("wr_to_timeout", tmo, 1'b1);

        // Misaligned address, response held for 5 cycles.
        do_txn(1'b1, 32'h6, 32'h99, 4'hF, 3'b000, 0, 1'b0, 32'h0, 5, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("mis_latency", lat, 0);
        check("mis_penable_cycles", npen, 0);
        check("mis_err", er, 1'b1);
        check("mis_timeout", tmo, 1'b0);

        // Reset in the middle of ACCESS, then a normal read.
        do_txn(1'b0, 32'h40, 32'h0, 4'hF, 3'b000, 100, 1'b0, 32'h0, 0, 1'b0, 3,
               lat, npen, st, rd, er, tmo);
        check("abort_no_rsp", lat, -1);
        repeat (3) @(negedge clk);
        do_txn(1'b0, 32'h44, 32'h0, 4'hF, 3'b000, 2, 1'b0, 32'h600D_F00D, 0, 1'b0, -1,
               lat, npen, st, rd, er, tmo);
        check("post_rst_latency", lat, 4);
        check("post_rst_rdata", rd, 32'h600D_F00D);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

Single-outstanding APB4 master that sits directly upstream of the APB4 CSR top. It converts a valid/ready command channel from the host side (debug UART, JTAG bridge or test sequencer) into compliant APB4 SETUP/ACCESS transfers. It returns read data and error status on a valid/ready response channel. A configurable PREADY timeout guarantees the host can never hang on a stalled slave.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr / paddr (the CSR slave consumes the low bits)
- DATA_WIDTH, 32, data width; must be 32 (pstrb is DATA_WIDTH/8 = 4 bits)
- TIMEOUT_CYCLES, 256, max ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  APB protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  pslverr, misalignment or timeout
- rsp_timeout  out  1  error was caused by the timeout
- psel, penable, pwrite  out  1  APB4 control
- paddr  out  ADDR_WIDTH  APB4 address
- pwdata  out  DATA_WIDTH  APB4 write data
- pstrb  out  DATA_WIDTH/8  APB4 strobes
- pprot  out  3  APB4 protection
- pready, pslverr  in  1  APB4 slave response
- prdata  in  DATA_WIDTH  APB4 read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state == IDLE). The command is captured into registers on cmd_valid && cmd_ready.
- IDLE transitions:
  - Aligned command (cmd_addr[1:0] == 0) -> SETUP.
  - Misaligned command -> RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No APB transfer is issued.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot driven from the captured command. Always -> ACCESS after one cycle.
- ACCESS: psel=1, penable=1; all APB outputs stay stable.
  - pready=1: capture rsp_err=pslverr. Capture rsp_rdata=prdata for reads only; rsp_rdata=0 for writes. -> RESP.
  - pready=0 and timeout enabled: increment the wait counter.
  - Wait counter reaches TIMEOUT_CYCLES: -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0. psel and penable drop on that edge.
  - pready=1 in the final counted cycle takes precedence over the timeout.
  - The counter clears on entry to SETUP and is sized $clog2(TIMEOUT_CYCLES+1).
- RESP: rsp_valid=1; rsp_* outputs are held stable until rsp_ready. Then -> IDLE.
- pstrb is forced to 0 on reads. It carries cmd_strb on writes.
- psel and penable are 0 in IDLE and RESP. paddr, pwdata, pwrite, pstrb and pprot hold their last values outside a transfer.
- Only one transaction is ever outstanding; there is no command buffering.

## Timing
- Reset (async assert) drives:
  - state=IDLE
  - psel, penable, pwrite, paddr, pwdata, pstrb, pprot all 0
  - rsp_valid, rsp_err, rsp_timeout, rsp_rdata all 0
  - cmd_ready=1 after reset release
- Reset asserted mid-transfer drops psel and penable immediately, without waiting for a clock edge. Any pending response is discarded.
- Command accepted at edge E0:
  - psel=1 from E0.
  - penable=1 from E1.
  - With pready=1 in the first ACCESS cycle, rsp_valid=1 from E2. Accept-to-response is 2 cycles with zero wait states.
- Each pready-low cycle adds one cycle of latency.
- Misaligned command: rsp_valid=1 from E0 (next cycle after accept).
- A timeout fires after exactly TIMEOUT_CYCLES ACCESS cycles with pready low. rsp_valid=1 on the following cycle.
- rsp_ready=1 while rsp_valid=1: response consumed at that edge. cmd_ready=1 the next cycle.
- Minimum back-to-back throughput: one transaction per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- cmd_* inputs are ignored while cmd_ready=0. prdata and pslverr are sampled only when psel && penable && pready.

## Test plan
- Zero-wait write: addr 0x4, data 0xDEADBEEF, strb 0xF. Required: psel/penable SETUP→ACCESS sequence with pwdata=0xDEADBEEF, pstrb=0xF; rsp_valid 2 cycles after accept; rsp_err=0; rsp_rdata=0.
- Read with 3 wait states: slave returns prdata=0x12345678 on the 4th ACCESS cycle. Required: APB outputs stable throughout; pstrb=0; rsp_rdata=0x12345678; rsp_valid 5 cycles after accept.
- Slave error: read with pslverr=1 and pready=1. Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=8, pready held low. Required: exactly 8 ACCESS cycles, then psel=0; rsp_err=1, rsp_timeout=1. Repeat with pready=1 in the 8th cycle: normal completion, rsp_timeout=0.
- Misaligned address 0x6: required: no psel activity; rsp_err=1 one cycle after accept. With rsp_ready=0 for 5 cycles, the response is held stable and cmd_ready stays 0.
- Reset asserted during ACCESS: psel and penable go to 0 asynchronously; no rsp_valid after release; the next command completes normally.
